// File: rtl/spi_resp.sv
// spi_resp: SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) oversampled on clk.
// Receives MOSI frames as a one-cycle rx_valid strobe and transmits bytes from
// a single-entry holding register, falling back to FILL_BYTE when it is empty.
module spi_resp #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = '0
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  sck,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);
    localparam int             CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            sck_s, ss_s;
    logic [1:0]            mosi_s;
    logic                  sck_rise, sck_fall, ss_rise, ss_fall;
    logic                  load, rx_bit, tx_shift_en, abort;
    logic [DATA_WIDTH-1:0] hold_q, tx_shift, rx_next;
    logic                  hold_full, load_pending;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [CW-1:0]         bit_cnt;

    // Two-flop synchronisers; the third sck/ss stage exists only for edge detection.
    // ss resets high so leaving reset does not look like a select.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_s  <= '0;
            ss_s   <= '1;
            mosi_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            ss_s   <= {ss_s[1:0], ss};
            mosi_s <= {mosi_s[0], mosi};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign ss_rise  = ss_s[1] & ~ss_s[2];
    assign ss_fall  = ~ss_s[1] & ss_s[2];
    assign rx_next  = {rx_shift, mosi_s[1]};
    assign tx_ready = ~hold_full;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle actions; a deselect edge masks any sck edge.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        rx_bit      = 1'b0;
        tx_shift_en = 1'b0;
        abort       = 1'b0;
        miso_oe     = 1'b0;
        busy        = 1'b0;
        miso        = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                miso_oe = 1'b1;
                busy    = 1'b1;
                miso    = tx_shift[DATA_WIDTH-1];
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sck_rise) begin
                    rx_bit = 1'b1;
                end else if (sck_fall) begin
                    if (load_pending) load = 1'b1;
                    else              tx_shift_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transmit side: holding register and MISO shifter. A load only consumes a
    // full register, so it never collides with a write (tx_ready is low then).
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_q      <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                if (hold_full) begin
                    tx_shift  <= hold_q;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift    <= FILL_BYTE;
                    tx_underrun <= 1'b1;
                end
            end else if (tx_shift_en) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (tx_valid && !hold_full) begin
                hold_q    <= tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    // Receive side: bit counter, MOSI shifter, frame strobe and the pending-load
    // flag that defers the next tx load to the following sck fall.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (abort) begin
                rx_shift     <= '0;
                bit_cnt      <= '0;
                load_pending <= 1'b0;
            end else if (rx_bit) begin
                rx_shift <= rx_next[DATA_WIDTH-2:0];
                if (bit_cnt == LAST) begin
                    bit_cnt      <= '0;
                    rx_data      <= rx_next;
                    rx_valid     <= 1'b1;
                    load_pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (load) begin
                load_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_resp.sv
// tb_spi_resp: drives spi_resp as an SPI master and checks it every cycle against
// an event-level reference model, plus literal expectations for directed frames.
module tb_spi_resp;
    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       nrst, sck, ss, mosi;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid;

    spi_resp #(.DATA_WIDTH(8), .FILL_BYTE(FILL)) dut (
        .clk(clk), .nrst(nrst), .sck(sck), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc_prints = 0;
    int urun_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] mo_a[4];
    logic [7:0] mi_a[4];
    int u0, u_last;

    // Reference model: pins seen through a fixed 2-cycle delay, events acted on
    // one cycle later. State kept at transaction level (byte + shift index).
    logic [3:0] hs, hk, hm;
    bit         m_sel, m_pend, m_full, m_rxv, m_ur;
    int         m_bits, m_acc, m_nshift;
    logic [7:0] m_cur, m_hold, m_rxd;

    task automatic m_reset();
        hs = 4'b1111; hk = 4'b0; hm = 4'b0;
        m_sel = 0; m_pend = 0; m_full = 0; m_rxv = 0; m_ur = 0;
        m_bits = 0; m_acc = 0; m_nshift = 0;
        m_cur = 8'h00; m_hold = 8'h00; m_rxd = 8'h00;
    endtask

    task automatic m_load(input bit full_before);
        if (full_before) begin
            m_cur  = m_hold;
            m_full = 0;
        end else begin
            m_cur = FILL;
            m_ur  = 1;
        end
        m_nshift = 0;
    endtask

    task automatic m_step();
        bit old_full, ss_f, ss_r, ck_r, ck_f;
        hs = {hs[2:0], ss};
        hk = {hk[2:0], sck};
        hm = {hm[2:0], mosi};
        ss_f = hs[3] & ~hs[2];
        ss_r = ~hs[3] & hs[2];
        ck_r = ~hk[3] & hk[2];
        ck_f = hk[3] & ~hk[2];
        m_rxv = 0;
        m_ur  = 0;
        old_full = m_full;
        if (!m_sel) begin
            if (ss_f) begin
                m_sel = 1;
                m_load(old_full);
            end
        end else if (ss_r) begin
            m_sel = 0; m_bits = 0; m_pend = 0; m_acc = 0;
        end else if (ck_r) begin
            m_acc  = ((m_acc * 2) + int'(hm[2])) % 256;
            m_bits = m_bits + 1;
            if (m_bits == 8) begin
                m_bits = 0;
                m_rxd  = 8'(m_acc);
                m_rxv  = 1;
                m_pend = 1;
            end
        end else if (ck_f) begin
            if (m_pend) begin
                m_load(old_full);
                m_pend = 0;
            end else begin
                m_nshift = m_nshift + 1;
            end
        end
        if (tx_valid && !old_full) begin
            m_hold = tx_data;
            m_full = 1;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) m_reset();
            else       m_step();
        end
    end

    // Per-cycle compare of every output against the model, plus monitors.
    initial begin
        logic [13:0] act, exp_v;
        bit e_miso;
        forever begin
            @(negedge clk);
            e_miso = m_sel && (m_nshift < 8) && m_cur[7 - m_nshift];
            exp_v  = {e_miso, m_sel, ~m_full, m_sel, m_rxv, m_ur, m_rxd};
            act    = {miso, miso_oe, tx_ready, busy, rx_valid, tx_underrun, rx_data};
            tests++;
            if (act !== exp_v) begin
                fails++;
                if (cyc_prints < 20) begin
                    cyc_prints++;
                    $display("FAIL cycle_compare t=%0t: got %h expected %h (miso,oe,rdy,busy,rxv,ur,rxd)",
                             $time, act, exp_v);
                end
            end
            if (rx_valid) rx_q.push_back(rx_data);
            if (tx_underrun) urun_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            chk("push_ready_timeout", 32'(tx_ready), 32'd1);
        end else begin
            tx_valid = 1'b1;
            tx_data  = d;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic try_push(input logic [7:0] d);
        if (tx_ready) begin
            tx_valid = 1'b1;
            tx_data  = d;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    // Master: mosi changes with sck fall, miso sampled at the end of each high phase.
    task automatic xfer(input int nbytes, input int nbits, input int half);
        u0 = urun_cnt;
        u_last = urun_cnt;
        for (int b = 0; b < 4; b++) mi_a[b] = 8'h00;
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo_a[i / 8][7 - (i % 8)];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            repeat (half) @(negedge clk);
            mi_a[i / 8][7 - (i % 8)] = miso;
            if (i == nbits - 1) u_last = urun_cnt;
            sck = 1'b0;
        end
        if (nbytes < 1) u_last = urun_cnt;
        repeat (half) @(negedge clk);
        ss = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [7:0] tb_tx[4];
        logic [7:0] tb_rx[4];
        nrst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {miso, miso_oe, tx_ready, busy, rx_valid, tx_underrun, rx_data},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        nrst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of bit 3 with the holding register full.
        ss = 1'b0;
        repeat (4) @(negedge clk);
        push(8'h77);
        chk("pre_reset_tx_ready", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        sck = 1'b1;
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("midframe_reset_outputs", {miso, miso_oe, tx_ready, busy, rx_valid, tx_underrun, rx_data},
            {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        ss = 1'b1; sck = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        // Single frame.
        rx_q.delete();
        push(8'hA5);
        mo_a[0] = 8'h3C;
        xfer(1, 8, 4);
        chk("single_miso", 32'(mi_a[0]), 32'hA5);
        chk("single_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("single_rx_data", 32'(rx_q[0]), 32'h3C);

        // Back-to-back frames, second byte written while the first is in flight.
        rx_q.delete();
        push(8'h11);
        mo_a[0] = 8'hF0; mo_a[1] = 8'h0F;
        fork
            xfer(2, 16, 4);
            begin
                repeat (12) @(negedge clk);
                push(8'h22);
            end
        join
        chk("b2b_miso0", 32'(mi_a[0]), 32'h11);
        chk("b2b_miso1", 32'(mi_a[1]), 32'h22);
        chk("b2b_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx0", 32'(rx_q[0]), 32'hF0);
            chk("b2b_rx1", 32'(rx_q[1]), 32'h0F);
        end
        chk("b2b_underruns", 32'(u_last - u0), 32'd0);

        // Underrun.
        rx_q.delete();
        mo_a[0] = 8'h55;
        xfer(1, 8, 4);
        chk("urun_miso", 32'(mi_a[0]), 32'(FILL));
        chk("urun_pulses", 32'(u_last - u0), 32'd1);
        chk("urun_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("urun_rx_data", 32'(rx_q[0]), 32'h55);

        // Abort after 5 bits, then a clean frame.
        rx_q.delete();
        mo_a[0] = 8'hFF;
        xfer(1, 5, 4);
        chk("abort_no_rx", 32'(rx_q.size()), 32'd0);
        mo_a[0] = 8'h81;
        xfer(1, 8, 4);
        chk("after_abort_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("after_abort_rx", 32'(rx_q[0]), 32'h81);

        // Minimum-rate stress: 2-clk phases, 4 frames under one select.
        rx_q.delete();
        for (int k = 0; k < 4; k++) begin
            tb_tx[k] = 8'($urandom);
            tb_rx[k] = 8'($urandom);
            mo_a[k]  = tb_rx[k];
        end
        push(tb_tx[0]);
        fork
            xfer(4, 32, 2);
            begin
                for (int k = 1; k < 4; k++) push(tb_tx[k]);
            end
        join
        chk("stress_rx_count", 32'(rx_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("stress_miso", 32'(mi_a[k]), 32'(tb_tx[k]));
            if (rx_q.size() == 4) chk("stress_rx", 32'(rx_q[k]), 32'(tb_rx[k]));
        end

        // Randomised transactions checked by the per-cycle model.
        for (int t = 0; t < 20; t++) begin
            int half, nb, nbits;
            half  = int'($urandom_range(2, 5));
            nb    = int'($urandom_range(1, 4));
            nbits = nb * 8;
            if ($urandom_range(0, 3) == 0) nbits = int'($urandom_range(1, nb * 8));
            for (int k = 0; k < 4; k++) mo_a[k] = 8'($urandom);
            fork
                xfer(nb, nbits, half);
                begin
                    for (int k = 0; k < 6; k++) begin
                        repeat ($urandom_range(2, 20)) @(negedge clk);
                        try_push(8'($urandom));
                    end
                end
            join
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
